// File: rtl/sdram_req_scheduler_if.sv
// Requester and SDRAM-controller bus for sdram_req_scheduler.
// Stats outputs exist only when SDRAM_SCHED_STATS_EN is defined.
interface sdram_req_scheduler_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 128
);
   logic              lb_req;
   logic [ADDR_W-1:0] lb_addr;
   logic              lb_ac;
   logic              pcm_req;
   logic [ADDR_W-1:0] pcm_addr;
   logic              pcm_ac;
   logic              bg_req;
   logic              bg_we;
   logic [ADDR_W-1:0] bg_addr;
   logic [DATA_W-1:0] bg_wrdata;
   logic              bg_ac;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              timeout_err;
   logic [ADDR_W-1:0] ar_addr;
   logic [15:0]       ar_be;
   logic              ar_read;
   logic              ar_write;
   logic [DATA_W-1:0] ar_wrdata;
   logic              ar_ac;
   logic [DATA_W-1:0] ar_rddata;
`ifdef SDRAM_SCHED_STATS_EN
   logic [31:0]       lb_grants;
   logic [31:0]       pcm_grants;
   logic [31:0]       bg_grants;
   logic [31:0]       timeout_count;
`endif

   // slave = scheduler side, master = requesters plus controller side
   modport slave (
      input  lb_req, lb_addr, pcm_req, pcm_addr, bg_req, bg_we, bg_addr, bg_wrdata,
      input  ar_ac, ar_rddata,
      output lb_ac, pcm_ac, bg_ac, rd_data, busy, timeout_err,
      output ar_addr, ar_be, ar_read, ar_write, ar_wrdata
`ifdef SDRAM_SCHED_STATS_EN
      , output lb_grants, pcm_grants, bg_grants, timeout_count
`endif
   );

   modport master (
      output lb_req, lb_addr, pcm_req, pcm_addr, bg_req, bg_we, bg_addr, bg_wrdata,
      output ar_ac, ar_rddata,
      input  lb_ac, pcm_ac, bg_ac, rd_data, busy, timeout_err,
      input  ar_addr, ar_be, ar_read, ar_write, ar_wrdata
`ifdef SDRAM_SCHED_STATS_EN
      , input lb_grants, pcm_grants, bg_grants, timeout_count
`endif
   );
endinterface

// File: rtl/sdram_req_scheduler.sv
// Single-transaction SDRAM port arbiter: lb > pcm > bg with bg starvation promotion and ack watchdog.
// Optional grant/abort counters enabled by defining SDRAM_SCHED_STATS_EN.
module sdram_req_scheduler #(
   parameter int ADDR_W          = 22,
   parameter int DATA_W          = 128,
   parameter int BG_STARVE_LIMIT = 64,
   parameter int ACK_TIMEOUT     = 255
) (
   input logic                  clk,
   input logic                  reset,
   input logic                  enable,
   sdram_req_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, DONE, GAP} state_t;
   typedef enum logic [1:0] {OWN_LB, OWN_PCM, OWN_BG} owner_t;

   localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
   localparam int SV_W = $clog2(BG_STARVE_LIMIT + 1);

   state_t            state;
   owner_t            owner;
   owner_t            pick;
   logic [WD_W-1:0]   wdog;
   logic [SV_W-1:0]   starve_cnt;
   logic              starve;
   logic              any_req;
   logic              grant;
   logic              complete;
   logic              abort;
   logic              bg_owner;

   logic              lb_ac, pcm_ac, bg_ac, busy, timeout_err, ar_read, ar_write;
   logic [ADDR_W-1:0] ar_addr;
   logic [DATA_W-1:0] ar_wrdata, rd_data;

   assign any_req  = bus.lb_req | bus.pcm_req | bus.bg_req;
   assign grant    = (state == IDLE) && enable && any_req;
   // ack on the watchdog's last cycle still counts as success
   assign complete = (state == ISSUE) && bus.ar_ac;
   assign abort    = (state == ISSUE) && !bus.ar_ac && (wdog == WD_W'(ACK_TIMEOUT - 1));
   assign starve   = (starve_cnt == SV_W'(BG_STARVE_LIMIT));
   assign bg_owner = busy && (owner == OWN_BG);

   always_comb begin
      pick = OWN_BG;
      if (bus.lb_req)                 pick = OWN_LB;
      else if (starve && bus.bg_req)  pick = OWN_BG;
      else if (bus.pcm_req)           pick = OWN_PCM;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!bus.bg_req || (grant && pick == OWN_BG)) begin
         starve_cnt <= '0;
      end else if (!bg_owner && !starve) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= OWN_LB;
         wdog        <= '0;
         lb_ac       <= 1'b0;
         pcm_ac      <= 1'b0;
         bg_ac       <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         ar_read     <= 1'b0;
         ar_write    <= 1'b0;
         ar_addr     <= '0;
         ar_wrdata   <= '0;
         rd_data     <= '0;
      end else begin
         lb_ac       <= 1'b0;
         pcm_ac      <= 1'b0;
         bg_ac       <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: if (grant) begin
               owner <= pick;
               busy  <= 1'b1;
               wdog  <= '0;
               state <= ISSUE;
               case (pick)
                  OWN_LB: begin
                     ar_addr <= bus.lb_addr;
                     ar_read <= 1'b1;
                  end
                  OWN_PCM: begin
                     ar_addr <= bus.pcm_addr;
                     ar_read <= 1'b1;
                  end
                  default: begin
                     ar_addr   <= bus.bg_addr;
                     ar_wrdata <= bus.bg_wrdata;
                     ar_read   <= !bus.bg_we;
                     ar_write  <= bus.bg_we;
                  end
               endcase
            end
            ISSUE: begin
               if (complete) begin
                  if (ar_read) rd_data <= bus.ar_rddata;
                  ar_read  <= 1'b0;
                  ar_write <= 1'b0;
                  state    <= DONE;
                  case (owner)
                     OWN_LB:  lb_ac  <= 1'b1;
                     OWN_PCM: pcm_ac <= 1'b1;
                     default: bg_ac  <= 1'b1;
                  endcase
               end else if (abort) begin
                  ar_read     <= 1'b0;
                  ar_write    <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= GAP;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            DONE: state <= GAP;
            GAP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.lb_ac       = lb_ac;
   assign bus.pcm_ac      = pcm_ac;
   assign bus.bg_ac       = bg_ac;
   assign bus.busy        = busy;
   assign bus.timeout_err = timeout_err;
   assign bus.ar_read     = ar_read;
   assign bus.ar_write    = ar_write;
   assign bus.ar_addr     = ar_addr;
   assign bus.ar_wrdata   = ar_wrdata;
   assign bus.rd_data     = rd_data;
   assign bus.ar_be       = 16'hFFFF;

`ifdef SDRAM_SCHED_STATS_EN
   logic [31:0] lb_grants, pcm_grants, bg_grants, timeout_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lb_grants     <= '0;
         pcm_grants    <= '0;
         bg_grants     <= '0;
         timeout_count <= '0;
      end else begin
         if (complete && owner == OWN_LB  && lb_grants  != '1) lb_grants  <= lb_grants + 1'b1;
         if (complete && owner == OWN_PCM && pcm_grants != '1) pcm_grants <= pcm_grants + 1'b1;
         if (complete && owner == OWN_BG  && bg_grants  != '1) bg_grants  <= bg_grants + 1'b1;
         if (abort && timeout_count != '1) timeout_count <= timeout_count + 1'b1;
      end
   end

   assign bus.lb_grants     = lb_grants;
   assign bus.pcm_grants    = pcm_grants;
   assign bus.bg_grants     = bg_grants;
   assign bus.timeout_count = timeout_count;
`endif
endmodule

// File: tb/tb_sdram_req_scheduler.sv
// Directed bench for sdram_req_scheduler: write, contention, starvation, read data, watchdog, async reset.
module tb_sdram_req_scheduler;
   localparam int ADDR_W = 22;
   localparam int DATA_W = 128;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   int   checks = 0;
   int   errors = 0;

   sdram_req_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sdram_req_scheduler #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BG_STARVE_LIMIT(8), .ACK_TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // present ar_ac with data for one cycle; returns in the DONE cycle
   task automatic ack(input logic [127:0] data);
      bus.ar_ac     = 1'b1;
      bus.ar_rddata = data;
      step();
      bus.ar_ac     = 1'b0;
      bus.ar_rddata = '0;
   endtask

   logic [127:0] a5, d1, d2, d3, dbf;
   int n_rd, n_to, n_ac, to_at;

   initial begin
      a5  = {16{8'hA5}};
      d1  = {4{32'h11110001}};
      d2  = {4{32'h22220002}};
      d3  = {4{32'h33330003}};
      dbf = {4{32'hDEADBEEF}};
      bus.lb_req = 0; bus.lb_addr = '0; bus.pcm_req = 0; bus.pcm_addr = '0;
      bus.bg_req = 0; bus.bg_we = 0; bus.bg_addr = '0; bus.bg_wrdata = '0;
      bus.ar_ac = 0; bus.ar_rddata = '0;

      // reset state
      step(); step();
      chk("rst_busy", bus.busy, 0);
      chk("rst_rd", bus.ar_read, 0);
      chk("rst_wr", bus.ar_write, 0);
      chk("rst_be", bus.ar_be, 16'hFFFF);
      chk("rst_rdata", bus.rd_data, 0);
      chk("rst_addr", bus.ar_addr, 0);
      chk("rst_to", bus.timeout_err, 0);
      reset = 0;

      // enable low: request is held off
      bus.bg_req = 1; bus.bg_we = 1; bus.bg_addr = 22'h00100; bus.bg_wrdata = a5;
      step(); step();
      chk("dis_busy", bus.busy, 0);
      chk("dis_wr", bus.ar_write, 0);

      // single bg write, ack in third strobe cycle
      enable = 1;
      step();
      chk("w1_wr", bus.ar_write, 1);
      chk("w1_rd", bus.ar_read, 0);
      chk("w1_addr", bus.ar_addr, 22'h00100);
      chk("w1_data", bus.ar_wrdata, a5);
      chk("w1_busy", bus.busy, 1);
      step();
      chk("w2_wr", bus.ar_write, 1);
      step();
      chk("w3_wr", bus.ar_write, 1);
      chk("w3_ac", bus.bg_ac, 0);
      ack(d3);
      bus.bg_req = 0;
      chk("wd_ac", bus.bg_ac, 1);
      chk("wd_wr", bus.ar_write, 0);
      chk("wd_rdata", bus.rd_data, 0);
      step();
      chk("wg_ac", bus.bg_ac, 0);
      chk("wg_busy", bus.busy, 1);
      step();
      chk("wi_busy", bus.busy, 0);

      // contention: lb, pcm, bg(read) at once
      bus.lb_req = 1; bus.lb_addr = 22'h11;
      bus.pcm_req = 1; bus.pcm_addr = 22'h22;
      bus.bg_req = 1; bus.bg_we = 0; bus.bg_addr = 22'h33;
      step();
      chk("c_lb_addr", bus.ar_addr, 22'h11);
      chk("c_lb_rd", bus.ar_read, 1);
      ack(d1);
      bus.lb_req = 0;
      chk("c_lb_ac", bus.lb_ac, 1);
      chk("c_lb_oth", {bus.pcm_ac, bus.bg_ac}, 0);
      chk("c_lb_data", bus.rd_data, d1);
      step();
      chk("c_gap1_rd", bus.ar_read, 0);
      step();
      chk("c_idle1_rd", bus.ar_read, 0);
      step();
      chk("c_pcm_addr", bus.ar_addr, 22'h22);
      ack(d2);
      bus.pcm_req = 0;
      chk("c_pcm_ac", bus.pcm_ac, 1);
      chk("c_pcm_data", bus.rd_data, d2);
      step(); step(); step();
      chk("c_bg_addr", bus.ar_addr, 22'h33);
      chk("c_bg_rd", bus.ar_read, 1);
      ack(d3);
      bus.bg_req = 0;
      chk("c_bg_ac", bus.bg_ac, 1);
      chk("c_bg_data", bus.rd_data, d3);
      step(); step();

      // starvation: pcm held, bg held; bg promoted on the third grant
      bus.pcm_req = 1; bus.pcm_addr = 22'h55;
      bus.bg_req = 1; bus.bg_we = 0; bus.bg_addr = 22'h44;
      step();
      chk("s1_addr", bus.ar_addr, 22'h55);
      ack(d1);
      chk("s1_ac", bus.pcm_ac, 1);
      step(); step(); step();
      chk("s2_addr", bus.ar_addr, 22'h55);
      ack(d2);
      chk("s2_ac", bus.pcm_ac, 1);
      step(); step(); step();
      chk("s3_bg_addr", bus.ar_addr, 22'h44);
      ack(d3);
      bus.bg_req = 0;
      chk("s3_bg_ac", bus.bg_ac, 1);
      chk("s3_pcm_ac", bus.pcm_ac, 0);
      step(); step(); step();
      chk("s4_addr", bus.ar_addr, 22'h55);
      ack(d1);
      bus.pcm_req = 0;
      chk("s4_ac", bus.pcm_ac, 1);
      step(); step();

      // read data at top address
      bus.pcm_req = 1; bus.pcm_addr = 22'h3FFFFF;
      step();
      chk("r_addr", bus.ar_addr, 22'h3FFFFF);
      ack(dbf);
      bus.pcm_req = 0;
      chk("r_ac", bus.pcm_ac, 1);
      chk("r_data", bus.rd_data, dbf);
      step(); step();
      chk("r_hold", bus.rd_data, dbf);

      // watchdog: lb read never acked
      bus.lb_req = 1; bus.lb_addr = 22'h77;
      step();
      bus.lb_req = 0;
      chk("t_addr", bus.ar_addr, 22'h77);
      n_rd = 0; n_to = 0; n_ac = 0; to_at = -1;
      for (int i = 0; i < 24; i++) begin
         if (bus.ar_read) n_rd++;
         if (bus.timeout_err) begin
            n_to++;
            if (to_at < 0) to_at = i;
         end
         if (bus.lb_ac | bus.pcm_ac | bus.bg_ac) n_ac++;
         step();
      end
      chk("t_rd_cycles", n_rd, 16);
      chk("t_to_pulses", n_to, 1);
      chk("t_to_when", to_at, 16);
      chk("t_no_ac", n_ac, 0);
      chk("t_rdata", bus.rd_data, dbf);

      // next request after abort proceeds normally
      bus.bg_req = 1; bus.bg_we = 1; bus.bg_addr = 22'h88; bus.bg_wrdata = d2;
      step();
      chk("p_wr", bus.ar_write, 1);
      chk("p_data", bus.ar_wrdata, d2);
      ack(d1);
      bus.bg_req = 0;
      chk("p_ac", bus.bg_ac, 1);
      chk("p_rdata", bus.rd_data, dbf);
      step(); step();
`ifdef SDRAM_SCHED_STATS_EN
      chk("st_lb", bus.lb_grants, 1);
      chk("st_pcm", bus.pcm_grants, 5);
      chk("st_bg", bus.bg_grants, 4);
      chk("st_to", bus.timeout_count, 1);
`endif

      // async reset mid-ISSUE
      bus.pcm_req = 1; bus.pcm_addr = 22'h99;
      step();
      chk("ar_pre_rd", bus.ar_read, 1);
      #2 reset = 1;
      #1;
      chk("ar_rd_now", bus.ar_read, 0);
      chk("ar_busy_now", bus.busy, 0);
      bus.pcm_req = 0;
      step();
      chk("ar_no_ac", {bus.lb_ac, bus.pcm_ac, bus.bg_ac}, 0);
      step();
      reset = 0;
      step();
      chk("ar_idle_busy", bus.busy, 0);
      chk("ar_idle_rd", bus.ar_read, 0);
      chk("ar_idle_ac", bus.pcm_ac, 0);
`ifdef SDRAM_SCHED_STATS_EN
      chk("ar_st_lb", bus.lb_grants, 0);
      chk("ar_st_pcm", bus.pcm_grants, 0);
      chk("ar_st_bg", bus.bg_grants, 0);
      chk("ar_st_to", bus.timeout_count, 0);
`endif
      bus.lb_req = 1; bus.lb_addr = 22'h5;
      step();
      chk("ar_next_addr", bus.ar_addr, 22'h5);
      ack(d1);
      bus.lb_req = 0;
      chk("ar_next_ac", bus.lb_ac, 1);
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
